// File: rtl/rc_req_sched.sv
// Ring-controller request buffer: up to BUF_MSB+1 pending requests, oldest-first issue per class
// (port 0 = read responses, port 1 = other commands). Optional ring credit gating: RC_SCHED_CREDIT_EN.
module rc_req_sched #(
  parameter int BUF_MSB      = 3,
  parameter int DATA_W       = 32,
  parameter int RING_CREDITS = 4
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              InValid,
  output logic                              InReady,
  input  logic                              InRdRsp,
  input  logic [DATA_W-1:0]                 InData,
  output logic                              Out0Valid,
  input  logic                              Out0Ready,
  output logic [DATA_W-1:0]                 Out0Data,
  output logic                              Out1Valid,
  input  logic                              Out1Ready,
  output logic [DATA_W-1:0]                 Out1Data,
  input  logic                              CreditRet,
  output logic [$clog2(RING_CREDITS+1)-1:0] CreditCnt,
  output logic [$clog2(BUF_MSB+2)-1:0]      Occupancy
);

  localparam int NE = BUF_MSB + 1;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam int CW = $clog2(RING_CREDITS + 1);
  localparam int OW = $clog2(BUF_MSB + 2);

  // Handshake rule for every port here: a transfer happens on a rising Clk
  // edge where valid and ready are both 1; valid and data never change while
  // valid is high and ready is low, and valid never depends on ready.
  typedef enum logic {P_IDLE, P_BUSY} port_state_e;

  logic [NE-1:0]         valid_q, valid_d;
  logic [NE-1:0]         lock_q, lock_d;
  logic [NE-1:0]         rd_q;
  logic [DATA_W-1:0]     data_q [NE];
  // older_q[i][j] = 1 means slot i is older than slot j
  logic [NE-1:0][NE-1:0] older_q, older_d;

  port_state_e           state_q [2];
  port_state_e           state_d [2];
  logic [IW-1:0]         idx_q   [2];
  logic [DATA_W-1:0]     out_data_q [2];

  logic [NE-1:0]         cand    [2];
  logic [IW-1:0]         sel     [2];
  logic                  hs      [2];
  logic                  latch   [2];
  logic                  gate    [2];
  logic                  port_rdy [2];
  logic                  gate1;

  logic                  alloc;
  logic [IW-1:0]         alloc_idx;
  logic [OW-1:0]         occ;

  function automatic logic [IW-1:0] pick_oldest(input logic [NE-1:0]         m,
                                                input logic [NE-1:0][NE-1:0] older);
    logic [IW-1:0] pick;
    logic          beaten;
    pick = '0;
    for (int i = 0; i < NE; i++) begin
      beaten = 1'b0;
      for (int j = 0; j < NE; j++) begin
        if (m[j] && older[j][i]) beaten = 1'b1;
      end
      if (m[i] && !beaten) pick = IW'(i);
    end
    return pick;
  endfunction

  // Allocation looks only at registered state, so a slot freed this cycle
  // cannot be reused until the next one.
  always_comb begin
    InReady   = ~&valid_q;
    alloc     = InValid && InReady;
    alloc_idx = '0;
    for (int i = NE - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IW'(i);
    end
  end

  always_comb begin
    cand[0]     = valid_q & ~lock_q & rd_q;
    cand[1]     = valid_q & ~lock_q & ~rd_q;
    gate[0]     = 1'b1;
    gate[1]     = gate1;
    port_rdy[0] = Out0Ready;
    port_rdy[1] = Out1Ready;
    for (int p = 0; p < 2; p++) begin
      sel[p]     = pick_oldest(cand[p], older_q);
      hs[p]      = (state_q[p] == P_BUSY) && port_rdy[p];
      latch[p]   = ((state_q[p] == P_IDLE) || hs[p]) && (|cand[p]) && gate[p];
      state_d[p] = state_q[p];
      if (latch[p])   state_d[p] = P_BUSY;
      else if (hs[p]) state_d[p] = P_IDLE;
    end
  end

  // Ports never touch the same slot: the departing one is LOCK, the newly
  // latched one is PEND, and the allocated one is FREE.
  always_comb begin
    valid_d = valid_q;
    lock_d  = lock_q;
    older_d = older_q;
    for (int p = 0; p < 2; p++) begin
      if (hs[p]) begin
        valid_d[idx_q[p]] = 1'b0;
        lock_d[idx_q[p]]  = 1'b0;
      end
      if (latch[p]) lock_d[sel[p]] = 1'b1;
    end
    if (alloc) begin
      valid_d[alloc_idx] = 1'b1;
      older_d[alloc_idx] = '0;
      for (int j = 0; j < NE; j++) begin
        if (IW'(j) != alloc_idx) older_d[j][alloc_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q <= '0;
      lock_q  <= '0;
      older_q <= '0;
      for (int p = 0; p < 2; p++) begin
        state_q[p]    <= P_IDLE;
        idx_q[p]      <= '0;
        out_data_q[p] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      lock_q  <= lock_d;
      older_q <= older_d;
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        if (latch[p]) begin
          idx_q[p]      <= sel[p];
          out_data_q[p] <= data_q[sel[p]];
        end
      end
    end
  end

  // Payload storage is only meaningful while the slot is valid; no reset needed.
  always_ff @(posedge Clk) begin
    if (alloc) begin
      data_q[alloc_idx] <= InData;
      rd_q[alloc_idx]   <= InRdRsp;
    end
  end

`ifdef RC_SCHED_CREDIT_EN
  logic [CW-1:0] credit_q, credit_d;

  always_comb begin
    credit_d = credit_q;
    if (latch[1] && !CreditRet)
      credit_d = credit_q - CW'(1);
    else if (!latch[1] && CreditRet && (credit_q != CW'(RING_CREDITS)))
      credit_d = credit_q + CW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) credit_q <= CW'(RING_CREDITS);
    else     credit_q <= credit_d;
  end

  assign gate1     = (credit_q != '0);
  assign CreditCnt = credit_q;
`else
  logic unused_credit_ret;
  assign unused_credit_ret = CreditRet;
  assign gate1             = 1'b1;
  assign CreditCnt         = '0;
`endif

  always_comb begin
    occ = '0;
    for (int i = 0; i < NE; i++) occ = occ + OW'(valid_q[i]);
  end

  assign Occupancy = occ;
  assign Out0Valid = (state_q[0] == P_BUSY);
  assign Out1Valid = (state_q[1] == P_BUSY);
  assign Out0Data  = out_data_q[0];
  assign Out1Data  = out_data_q[1];

endmodule

// File: tb/tb_rc_req_sched.sv
// Bench for rc_req_sched: table vectors, directed corner sequences and random traffic
// checked against an age-ordered queue model plus per-class expected-data queues.
module tb_rc_req_sched;

  localparam int NE = 4;
  localparam int DW = 32;
  localparam int RC = 4;
  localparam int CW = $clog2(RC + 1);
  localparam int OW = $clog2(NE + 1);
`ifdef RC_SCHED_CREDIT_EN
  localparam int CRED_RST = RC;
`else
  localparam int CRED_RST = 0;
`endif

  logic          Clk, Rst;
  logic          InValid, InReady, InRdRsp;
  logic [DW-1:0] InData;
  logic          Out0Valid, Out0Ready, Out1Valid, Out1Ready;
  logic [DW-1:0] Out0Data, Out1Data;
  logic          CreditRet;
  logic [CW-1:0] CreditCnt;
  logic [OW-1:0] Occupancy;

  rc_req_sched #(.BUF_MSB(NE - 1), .DATA_W(DW), .RING_CREDITS(RC)) dut (
    .Clk(Clk), .Rst(Rst),
    .InValid(InValid), .InReady(InReady), .InRdRsp(InRdRsp), .InData(InData),
    .Out0Valid(Out0Valid), .Out0Ready(Out0Ready), .Out0Data(Out0Data),
    .Out1Valid(Out1Valid), .Out1Ready(Out1Ready), .Out1Data(Out1Data),
    .CreditRet(CreditRet), .CreditCnt(CreditCnt), .Occupancy(Occupancy)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: pending entries in age order, oldest first
  typedef struct {
    logic [DW-1:0] data;
    logic          rd;
    logic          locked;
  } ent_t;

  ent_t          m_q[$];
  logic          m_busy [2];
  logic [DW-1:0] m_dat  [2];
  int            m_cred;

  // scoreboard: expected issue order per class
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  task automatic model_step(input logic rst, input logic inv, input logic rd,
                            input logic [DW-1:0] d, input logic r0, input logic r1,
                            input logic cr);
    logic hs [2];
    logic lat [2];
    int   cand [2];
    logic in_rdy, gate1, found;
    if (rst) begin
      m_q.delete();
      exp_q0.delete();
      exp_q1.delete();
      for (int p = 0; p < 2; p++) begin
        m_busy[p] = 1'b0;
        m_dat[p]  = '0;
      end
      m_cred = CRED_RST;
      return;
    end
    in_rdy = (m_q.size() < NE);
`ifdef RC_SCHED_CREDIT_EN
    gate1 = (m_cred > 0);
`else
    gate1 = 1'b1;
`endif
    hs[0] = m_busy[0] && r0;
    hs[1] = m_busy[1] && r1;
    for (int p = 0; p < 2; p++) begin
      if (hs[p]) begin
        found = 1'b0;
        for (int i = 0; i < m_q.size(); i++) begin
          if (!found && m_q[i].locked && (m_q[i].rd == (p == 0))) begin
            m_q.delete(i);
            found = 1'b1;
          end
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      cand[p] = -1;
      for (int i = 0; i < m_q.size(); i++) begin
        if (cand[p] < 0 && !m_q[i].locked && (m_q[i].rd == (p == 0))) cand[p] = i;
      end
      lat[p] = (!m_busy[p] || hs[p]) && (cand[p] >= 0) && ((p == 0) || gate1);
      if (lat[p]) begin
        m_q[cand[p]].locked = 1'b1;
        m_dat[p]  = m_q[cand[p]].data;
        m_busy[p] = 1'b1;
      end else if (hs[p]) begin
        m_busy[p] = 1'b0;
      end
    end
`ifdef RC_SCHED_CREDIT_EN
    m_cred = m_cred + (cr ? 1 : 0) - (lat[1] ? 1 : 0);
    if (m_cred > RC) m_cred = RC;
`else
    if (cr) m_cred = 0;
`endif
    if (inv && in_rdy) begin
      m_q.push_back('{data: d, rd: rd, locked: 1'b0});
      if (rd) exp_q0.push_back(d);
      else    exp_q1.push_back(d);
    end
  endtask

  task automatic compare_model();
    chk("in_ready", 32'(InReady), 32'(m_q.size() < NE));
    chk("occupancy", 32'(Occupancy), 32'(m_q.size()));
    chk("out0_valid", 32'(Out0Valid), 32'(m_busy[0]));
    chk("out1_valid", 32'(Out1Valid), 32'(m_busy[1]));
    if (m_busy[0]) chk("out0_data", Out0Data, m_dat[0]);
    if (m_busy[1]) chk("out1_data", Out1Data, m_dat[1]);
    chk("credit_cnt", 32'(CreditCnt), 32'(m_cred));
  endtask

  // driver: one clock cycle; inputs change 1 time unit after the edge
  task automatic cycle(input logic rst, input logic inv, input logic rd,
                       input logic [DW-1:0] d, input logic r0, input logic r1,
                       input logic cr);
    logic          h0, h1;
    logic [DW-1:0] hd0, hd1, e;
    Rst = rst; InValid = inv; InRdRsp = rd; InData = d;
    Out0Ready = r0; Out1Ready = r1; CreditRet = cr;
    h0 = Out0Valid && r0 && !rst;
    h1 = Out1Valid && r1 && !rst;
    hd0 = Out0Data;
    hd1 = Out1Data;
    @(posedge Clk);
    if (h0) begin
      if (exp_q0.size() == 0) chk("sb0_unexpected_issue", hd0, 32'hDEAD_0000);
      else begin e = exp_q0.pop_front(); chk("sb0_order", hd0, e); end
    end
    if (h1) begin
      if (exp_q1.size() == 0) chk("sb1_unexpected_issue", hd1, 32'hDEAD_0001);
      else begin e = exp_q1.pop_front(); chk("sb1_order", hd1, e); end
    end
    model_step(rst, inv, rd, d, r0, r1, cr);
    #1;
    compare_model();
  endtask

  task automatic idle(input logic r0, input logic r1, input logic cr);
    cycle(1'b0, 1'b0, 1'b0, '0, r0, r1, cr);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic          inv;
    logic [DW-1:0] d;
    logic          r1;
    logic          e_rdy;
    logic [OW-1:0] e_occ;
    logic          e_v1;
    logic [DW-1:0] e_d1;
  } vec_t;

  function automatic vec_t mk(input logic inv, input logic [DW-1:0] d, input logic r1,
                              input logic e_rdy, input logic [OW-1:0] e_occ,
                              input logic e_v1, input logic [DW-1:0] e_d1);
    vec_t v;
    v.inv = inv; v.d = d; v.r1 = r1;
    v.e_rdy = e_rdy; v.e_occ = e_occ; v.e_v1 = e_v1; v.e_d1 = e_d1;
    return v;
  endfunction

  vec_t tbl [9];

  initial begin
    // four class-1 writes with the ring stalled, a rejected fifth, then drain
    tbl[0] = mk(1'b1, 32'h11, 1'b0, 1'b1, 3'd1, 1'b0, 32'h0);
    tbl[1] = mk(1'b1, 32'h22, 1'b0, 1'b1, 3'd2, 1'b1, 32'h11);
    tbl[2] = mk(1'b1, 32'h33, 1'b0, 1'b1, 3'd3, 1'b1, 32'h11);
    tbl[3] = mk(1'b1, 32'h44, 1'b0, 1'b0, 3'd4, 1'b1, 32'h11);
    tbl[4] = mk(1'b1, 32'h55, 1'b0, 1'b0, 3'd4, 1'b1, 32'h11);
    tbl[5] = mk(1'b0, 32'h0,  1'b1, 1'b1, 3'd3, 1'b1, 32'h22);
    tbl[6] = mk(1'b0, 32'h0,  1'b1, 1'b1, 3'd2, 1'b1, 32'h33);
    tbl[7] = mk(1'b0, 32'h0,  1'b1, 1'b1, 3'd1, 1'b1, 32'h44);
    tbl[8] = mk(1'b0, 32'h0,  1'b1, 1'b1, 3'd0, 1'b0, 32'h0);

    Rst = 1'b1; InValid = 1'b0; InRdRsp = 1'b0; InData = '0;
    Out0Ready = 1'b0; Out1Ready = 1'b0; CreditRet = 1'b0;
    m_cred = CRED_RST;
    do_reset();
    do_reset();
    chk("rst_in_ready", 32'(InReady), 32'd1);
    chk("rst_occupancy", 32'(Occupancy), 32'd0);
    chk("rst_out0_valid", 32'(Out0Valid), 32'd0);
    chk("rst_out1_valid", 32'(Out1Valid), 32'd0);
    chk("rst_out0_data", Out0Data, 32'd0);
    chk("rst_out1_data", Out1Data, 32'd0);
    chk("rst_credit", 32'(CreditCnt), 32'(CRED_RST));

    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, tbl[i].inv, 1'b0, tbl[i].d, 1'b0, tbl[i].r1, 1'b0);
      chk($sformatf("tbl%0d_in_ready", i), 32'(InReady), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_occupancy", i), 32'(Occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_out1_valid", i), 32'(Out1Valid), 32'(tbl[i].e_v1));
      if (tbl[i].e_v1) chk($sformatf("tbl%0d_out1_data", i), Out1Data, tbl[i].e_d1);
    end

    // interleaved classes, dual handshake, back-to-back on port 0
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'hB0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    chk("mix_occ_before", 32'(Occupancy), 32'd3);
    chk("mix_out0_first", Out0Data, 32'hA0);
    chk("mix_out1_first", Out1Data, 32'hB0);
    idle(1'b1, 1'b1, 1'b0);
    chk("mix_occ_dual_hs", 32'(Occupancy), 32'd1);
    chk("mix_out0_b2b_valid", 32'(Out0Valid), 32'd1);
    chk("mix_out0_b2b_data", Out0Data, 32'hA1);
    idle(1'b1, 1'b1, 1'b0);
    chk("mix_occ_empty", 32'(Occupancy), 32'd0);

    // full, drain one in cycle N, reuse at N+1 as youngest
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'h61 + 32'(i), 1'b0, 1'b0, 1'b1);
    chk("full_in_ready", 32'(InReady), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h65, 1'b0, 1'b1, 1'b1);
    chk("free_in_ready_next", 32'(InReady), 32'd1);
    chk("free_occ", 32'(Occupancy), 32'd3);
    cycle(1'b0, 1'b1, 1'b0, 32'h66, 1'b0, 1'b0, 1'b1);
    chk("refill_occ", 32'(Occupancy), 32'd4);
    chk("refill_out1_data", Out1Data, 32'h62);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b1, 1'b1);
    chk("refill_drained", 32'(Occupancy), 32'd0);

    // age order after reuse of slot 0
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 32'hC0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 32'hC1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'hC2, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'hC3, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b1, 1'b1);
    chk("age_out1_after_free", Out1Data, 32'hC2);
    cycle(1'b0, 1'b1, 1'b0, 32'hEE, 1'b0, 1'b0, 1'b1);
    chk("age_occ_full", 32'(Occupancy), 32'd4);
    idle(1'b1, 1'b1, 1'b1);
    chk("age_out1_second", Out1Data, 32'hC3);
    idle(1'b1, 1'b1, 1'b1);
    chk("age_out1_third", Out1Data, 32'hEE);
    idle(1'b1, 1'b1, 1'b1);
    chk("age_drained", 32'(Occupancy), 32'd0);

`ifdef RC_SCHED_CREDIT_EN
    // credits exhausted, one return releases the stalled entry, saturation
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'hD0 + 32'(i), 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    chk("cred_exhausted", 32'(CreditCnt), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'hD4, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b1, 1'b0);
    chk("cred_stalled_valid", 32'(Out1Valid), 32'd0);
    chk("cred_stalled_occ", 32'(Occupancy), 32'd1);
    idle(1'b0, 1'b0, 1'b1);
    chk("cred_returned", 32'(CreditCnt), 32'd1);
    idle(1'b0, 1'b0, 1'b0);
    chk("cred_release_valid", 32'(Out1Valid), 32'd1);
    chk("cred_release_data", Out1Data, 32'hD4);
    chk("cred_back_to_zero", 32'(CreditCnt), 32'd0);
    for (int i = 0; i < 6; i++) idle(1'b0, 1'b1, 1'b1);
    chk("cred_saturated", 32'(CreditCnt), 32'(RC));
`else
    // credit return has no effect in this build
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0, 1'b1);
    chk("cred_tied_zero", 32'(CreditCnt), 32'd0);
`endif

    // reset while both ports are busy
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 32'hF0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'hF1, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    chk("pre_rst_both_busy", 32'({Out0Valid, Out1Valid}), 32'd3);
    do_reset();
    chk("mid_rst_out0_valid", 32'(Out0Valid), 32'd0);
    chk("mid_rst_out1_valid", 32'(Out1Valid), 32'd0);
    chk("mid_rst_occ", 32'(Occupancy), 32'd0);
    chk("mid_rst_credit", 32'(CreditCnt), 32'(CRED_RST));
    chk("mid_rst_in_ready", 32'(InReady), 32'd1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(499) == 0,
            $urandom_range(3) != 0,
            $urandom_range(1) == 1,
            $urandom,
            $urandom_range(2) != 0,
            $urandom_range(2) != 0,
            $urandom_range(3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rc_req_sched.md
Name: rc_req_sched

Overview:
- Ring-controller request buffer and scheduler. Holds up to BUF_MSB+1 pending requests and splits them into two classes: read responses and all other commands.
- Issues the oldest pending entry of each class to its own output port. Class 0 (read responses) goes to the core side; class 1 (other commands) goes to the ring.
- Owns slot allocation, an internal age ordering (allocate / dealloc / oldest-per-mask), per-port issue locking and ring-side credit accounting.

Parameters:
- BUF_MSB, 3, buffer entries minus one (4 entries).
- DATA_W, 32, request payload width.
- RING_CREDITS, 4, initial ring credits for port 1.

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous active-high reset
- InValid  in  1  incoming request valid
- InReady  out  1  buffer can accept
- InRdRsp  in  1  1 = read response (class 0), 0 = other command (class 1)
- InData  in  DATA_W  payload
- Out0Valid  out  1  class-0 issue valid
- Out0Ready  in  1  class-0 consumer accept
- Out0Data  out  DATA_W  class-0 payload
- Out1Valid  out  1  class-1 issue valid
- Out1Ready  in  1  class-1 consumer accept
- Out1Data  out  DATA_W  class-1 payload
- CreditRet  in  1  ring returns one credit
- CreditCnt  out  $clog2(RING_CREDITS+1)  current ring credits
- Occupancy  out  $clog2(BUF_MSB+2)  valid entry count

Behaviour:
- Clocking and reset:
  - Single clock Clk; Rst is synchronous, active-high.
  - Reset values: all entries FREE, age state cleared, Out0Valid/Out1Valid=0, Out0Data/Out1Data=0, Occupancy=0, CreditCnt=RING_CREDITS, InReady=1 from the first cycle after reset.
  - Reset mid-operation drops all entries and locked issues without any handshake.
- Entry state (per slot): FREE -> PEND (on allocation) -> LOCK (latched by its port) -> FREE (on port handshake).
- Allocation:
  - InReady = (any FREE slot), computed from registered state only.
  - On InValid&InReady, the lowest-index FREE slot is written (payload, class bit) and enters PEND. It becomes the youngest in age order.
  - A slot freed in cycle N is allocatable from N+1, never the same cycle.
- Selection (per port p):
  - Candidates are PEND entries of class p, excluding LOCK entries.
  - Pick the oldest by age order. Ties are impossible; there is exactly one oldest.
- Port state machine (per port): IDLE / BUSY.
  - IDLE: if a candidate exists (and, for port 1, the credit gate passes), latch its index, mark it LOCK, go BUSY. OutpValid rises the next cycle.
  - BUSY: OutpValid=1 and OutpData held stable until OutpReady. On handshake the entry is deallocated (FREE, removed from age order).
  - Back-to-back issue: on the handshake cycle, if another candidate exists (excluding the departing entry), it is latched directly and the port stays BUSY. Otherwise the port goes IDLE. There is no bubble between consecutive entries.
- Issue latency: 1 cycle from allocation to OutpValid when the port is IDLE.
- Age order: an entry allocated in the same cycle as a dealloc is younger than every surviving entry.
- Occupancy:
  - +1 on allocation, -1 per handshake; two handshakes in one cycle give -2.
  - Simultaneous allocation and handshake updates net.
- Full: with all entries PEND/LOCK, InReady=0. InValid is then ignored and the payload is not captured.
- Both ports may handshake in the same cycle; they never select the same entry because the classes are disjoint.

Optional Feature:
- Macro: RC_SCHED_CREDIT_EN.
- Defined:
  - Port 1 latches only when CreditCnt>0. Each latch decrements CreditCnt; each CreditRet increments it.
  - Latch and return in the same cycle leave the count unchanged.
  - CreditRet at CreditCnt==RING_CREDITS saturates; the count is not incremented.
- Undefined: port 1 is ungated, CreditRet is ignored, and CreditCnt is tied to 0.

Test Plan:
- Reset, then 4 class-1 writes D=0x11,0x22,0x33,0x44 with Out1Ready=0 -> InReady=0 after the 4th, Occupancy=4, Out1Data=0x11 held. A 5th write with InValid=1 is not accepted.
- Interleave class 0 (0xA0,0xA1) and class 1 (0xB0), both Ready=1 -> Out0 issues 0xA0 then 0xA1 back-to-back, Out1 issues 0xB0. Both handshake in the same cycle with Occupancy dropping by 2.
- Fill to full, drain one entry via Out1 handshake in cycle N -> InReady=1 at N+1, and a new write lands in the freed slot as the youngest entry.
- Allocate slots 0..3 (classes 1,0,1,1), free slot 0, allocate 0xEE (class 1) into slot 0 -> Out1 issue order is slot2, slot3, 0xEE.
- RC_SCHED_CREDIT_EN, RING_CREDITS=2, 3 class-1 entries, Out1Ready=1 -> only 2 are issued and CreditCnt=0. One CreditRet pulse issues the 3rd, and CreditCnt returns to 0.
- Assert Rst while both ports are BUSY -> next cycle Out0Valid=Out1Valid=0, Occupancy=0, CreditCnt=RING_CREDITS, InReady=1.
